// File: rtl/rom_burst_reader_pkg.sv
// Shared definitions for the burst ROM reader: FSM encoding and content constants.
package rom_burst_reader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int unsigned ROM_MULT     = 29;
  localparam int unsigned DEFAULT_SEED = 32'h5A;

endpackage

// File: rtl/rom_burst_reader_rom.sv
// Pure combinational table lookup: word(a) = (a*29 + SEED) mod 2**DATA_W for a < DEPTH,
// zero with oor_o raised for unpopulated addresses.
module rom_case_param
  import rom_burst_reader_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 40,
  parameter int unsigned SEED   = DEFAULT_SEED
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic [DATA_W-1:0] data_o,
  output logic              oor_o
);

  // NOTE: every output gets a value on every path through always_comb, so no latch is inferred.
  always_comb begin
    oor_o  = (32'(addr_i) >= DEPTH);
    data_o = '0;
    case (oor_o)
      1'b0:    data_o = DATA_W'(32'(addr_i) * ROM_MULT + SEED);
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/rom_burst_reader.sv
// Registered ROM reader with single/burst requests, wrap-at-DEPTH addressing,
// valid/ready output handshake and out-of-range flagging.
module rom_burst_reader
  import rom_burst_reader_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 40,
  parameter int unsigned LEN_W  = 4,
  parameter int unsigned SEED   = DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              ce_i,
  input  logic              ren_i,
  input  logic              burst_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              last_o,
  output logic              busy_o,
  output logic              err_o,
  output logic              drop_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t              state_q;
  logic [ADDR_W-1:0]   cur_addr_q;
  logic [LEN_W-1:0]    remaining_q;
  logic [DATA_W-1:0]   data_q;
  logic                valid_q, last_q, busy_q, err_q, drop_q;

  logic                req;
  logic                slot_free;
  logic [ADDR_W-1:0]   next_addr;
  logic [DATA_W-1:0]   rom_data;
  logic                rom_oor;

  assign req       = ce_i & ren_i;
  assign slot_free = ~valid_q | ready_i;
  // Wrap only from the last populated word; out-of-range addresses roll over at 2**ADDR_W.
  assign next_addr = (cur_addr_q == LAST_ADDR) ? '0 : cur_addr_q + ADDR_W'(1);

  rom_case_param #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .SEED   (SEED)
  ) u_rom (
    .addr_i (cur_addr_q),
    .data_o (rom_data),
    .oor_o  (rom_oor)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      drop_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req) begin
            cur_addr_q  <= addr_i;
            remaining_q <= burst_i ? len_i : '0;
            busy_q      <= 1'b1;
            state_q     <= RUN;
          end
        end
        RUN: begin
          drop_q <= req;
          if (slot_free) begin
            data_q      <= rom_data;
            valid_q     <= 1'b1;
            last_q      <= (remaining_q == '0);
            err_q       <= rom_oor;
            cur_addr_q  <= next_addr;
            remaining_q <= remaining_q - LEN_W'(1);
            if (remaining_q == '0) state_q <= HOLD;
          end
        end
        HOLD: begin
          drop_q <= req;
          if (valid_q && ready_i) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign last_o  = last_q;
  assign busy_o  = busy_q;
  assign err_o   = err_q;
  assign drop_o  = drop_q;

endmodule

// File: tb/tb_rom_burst_reader.sv
// Directed self-checking bench for rom_burst_reader with hand-computed expected words.
module tb_rom_burst_reader;

  logic       clk = 1'b0;
  logic       resetn;
  logic       ce, ren, burst, ready;
  logic [3:0] len;
  logic [7:0] addr;
  logic [7:0] data;
  logic       valid, last, busy, err, drop;

  int total = 0;
  int bad   = 0;

  rom_burst_reader dut (
    .clk     (clk),
    .resetn  (resetn),
    .ce_i    (ce),
    .ren_i   (ren),
    .burst_i (burst),
    .len_i   (len),
    .addr_i  (addr),
    .data_o  (data),
    .valid_o (valid),
    .ready_i (ready),
    .last_o  (last),
    .busy_o  (busy),
    .err_o   (err),
    .drop_o  (drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic [7:0] a, input logic b, input logic [3:0] l);
    ce = 1'b1; ren = 1'b1; addr = a; burst = b; len = l;
    tick();
    ce = 1'b0; ren = 1'b0;
  endtask

  task automatic expect_beat(input string tag, input logic [7:0] d, input logic l, input logic e);
    check({tag, ".valid"}, valid, 1'b1);
    check({tag, ".data"},  data,  d);
    check({tag, ".last"},  last,  l);
    check({tag, ".err"},   err,   e);
  endtask

  task automatic expect_idle(input string tag);
    check({tag, ".valid"}, valid, 1'b0);
    check({tag, ".busy"},  busy,  1'b0);
  endtask

  function automatic logic [7:0] word_of(input int a);
    return 8'((a * 29 + 90) % 256);
  endfunction

  initial begin
    resetn = 1'b0; ce = 1'b0; ren = 1'b0; burst = 1'b0; len = '0; addr = '0; ready = 1'b1;
    #12;
    check("rst.data", data, 8'h00);
    check("rst.valid", valid, 1'b0);
    check("rst.last", last, 1'b0);
    check("rst.busy", busy, 1'b0);
    check("rst.err", err, 1'b0);
    check("rst.drop", drop, 1'b0);
    @(negedge clk);
    resetn = 1'b1;
    tick();
    expect_idle("idle");

    // 1: single read addr 0
    request(8'd0, 1'b0, 4'd0);
    check("t1.busy_accept", busy, 1'b1);
    check("t1.valid_accept", valid, 1'b0);
    tick();
    expect_beat("t1.beat", 8'h5A, 1'b1, 1'b0);
    tick();
    expect_idle("t1.done");

    // 2: burst wrapping at DEPTH
    request(8'd38, 1'b1, 4'd3);
    tick(); expect_beat("t2.b0", 8'hA8, 1'b0, 1'b0);
    tick(); expect_beat("t2.b1", 8'hC5, 1'b0, 1'b0);
    tick(); expect_beat("t2.b2", 8'h5A, 1'b0, 1'b0);
    tick(); expect_beat("t2.b3", 8'h77, 1'b1, 1'b0);
    tick(); expect_idle("t2.done");

    // 3: backpressure holds the first beat
    request(8'd0, 1'b1, 4'd2);
    tick(); expect_beat("t3.b0", 8'h5A, 1'b0, 1'b0);
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); expect_beat("t3.hold", 8'h5A, 1'b0, 1'b0);
    end
    ready = 1'b1;
    tick(); expect_beat("t3.b1", 8'h77, 1'b0, 1'b0);
    tick(); expect_beat("t3.b2", 8'h94, 1'b1, 1'b0);
    tick(); expect_idle("t3.done");

    // 4: out-of-range single, then burst across the wrap point
    request(8'd40, 1'b0, 4'd0);
    tick(); expect_beat("t4.oor", 8'h00, 1'b1, 1'b1);
    tick(); expect_idle("t4.oor_done");
    request(8'd39, 1'b1, 4'd1);
    tick(); expect_beat("t4.b0", 8'hC5, 1'b0, 1'b0);
    tick(); expect_beat("t4.b1", 8'h5A, 1'b1, 1'b0);
    tick(); expect_idle("t4.done");

    // 5: request while busy drops, then asynchronous reset mid-burst
    request(8'd5, 1'b1, 4'd7);
    tick(); expect_beat("t5.b0", 8'hEB, 1'b0, 1'b0);
    check("t5.nodrop0", drop, 1'b0);
    tick(); expect_beat("t5.b1", 8'h08, 1'b0, 1'b0);
    ce = 1'b1; ren = 1'b1; addr = 8'd20; burst = 1'b0;
    tick(); expect_beat("t5.b2", 8'h25, 1'b0, 1'b0);
    check("t5.drop", drop, 1'b1);
    ce = 1'b0; ren = 1'b0;
    tick(); expect_beat("t5.b3", 8'h42, 1'b0, 1'b0);
    check("t5.drop_clear", drop, 1'b0);
    resetn = 1'b0;
    #1;
    check("t5.rst.data", data, 8'h00);
    check("t5.rst.valid", valid, 1'b0);
    check("t5.rst.last", last, 1'b0);
    check("t5.rst.busy", busy, 1'b0);
    check("t5.rst.err", err, 1'b0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); expect_idle("t5.after_rst");
    end

    // 6: sweep of single reads over every populated word
    for (int a = 0; a < 40; a++) begin
      request(8'(a), 1'b0, 4'd0);
      tick(); expect_beat($sformatf("t6.a%0d", a), word_of(a), 1'b1, 1'b0);
      tick();
    end
    expect_idle("t6.done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
